cdr_phase_controller: RTL and testbench

CDR_PHASE_CONTROLLER -- requirements
Module: cdr_phase_controller

---
 rtl/cdr_phase_controller.sv | 132 +++++++++++++
 tb/tb_cdr_phase_controller.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdr_phase_controller.sv
// Bang-bang CDR phase controller: vote accumulator, post-step holdoff, acquisition/track step sizing.
// Optional override port pair enabled by defining CDR_PHASE_OVERRIDE_EN.
module cdr_phase_controller #(
    parameter int VOTE_THRESH = 8,
    parameter int HOLDOFF     = 4,
    parameter int ACQ_STEP    = 4,
    parameter int LOCK_REV    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pd_valid,
    input  logic       pd_early,
    input  logic       pd_late,
`ifdef CDR_PHASE_OVERRIDE_EN
    input  logic       ovr_en,
    input  logic [8:0] ovr_code,
`endif
    output logic [8:0] phase_shift,
    output logic       phase_update,
    output logic       locked
);

    localparam int ACC_W = $clog2(VOTE_THRESH) + 2;
    localparam logic signed [ACC_W-1:0] THR_P = ACC_W'(VOTE_THRESH);
    localparam logic signed [ACC_W-1:0] THR_N = -THR_P;
    localparam logic [3:0] LOCK_N = 4'(LOCK_REV);

    typedef enum logic {ACCUM, HOLD} state_t;

    state_t                  state;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] vote;
    logic signed [ACC_W-1:0] acc_sum;
    logic [3:0]              hold_cnt;
    logic [3:0]              rev_cnt;
    logic [3:0]              same_cnt;
    logic [3:0]              rev_nx;
    logic [3:0]              same_nx;
    logic                    have_dir;
    logic                    last_up;
    logic                    hit_up;
    logic                    hit_dn;
    logic [8:0]              step_mag;

    always_comb begin
        vote = '0;
        if (pd_valid && pd_late && !pd_early)
            vote = ACC_W'(1);
        else if (pd_valid && pd_early && !pd_late)
            vote = '1;
        acc_sum  = acc + vote;
        hit_up   = (acc_sum == THR_P);
        hit_dn   = (acc_sum == THR_N);
        step_mag = locked ? 9'd1 : 9'(ACQ_STEP);

        // First step after reset has no history and counts as neither direction class.
        rev_nx  = rev_cnt;
        same_nx = same_cnt;
        if (have_dir) begin
            if (hit_up != last_up) begin
                rev_nx  = (rev_cnt == LOCK_N) ? rev_cnt : rev_cnt + 4'd1;
                same_nx = '0;
            end else begin
                same_nx = (same_cnt == LOCK_N) ? same_cnt : same_cnt + 4'd1;
                rev_nx  = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ACCUM;
            acc          <= '0;
            hold_cnt     <= '0;
            rev_cnt      <= '0;
            same_cnt     <= '0;
            have_dir     <= 1'b0;
            last_up      <= 1'b0;
            phase_shift  <= '0;
            phase_update <= 1'b0;
            locked       <= 1'b0;
`ifdef CDR_PHASE_OVERRIDE_EN
        end else if (ovr_en) begin
            phase_shift  <= ovr_code;
            phase_update <= (ovr_code != phase_shift);
            acc          <= '0;
            rev_cnt      <= '0;
            same_cnt     <= '0;
            hold_cnt     <= '0;
            state        <= ACCUM;
`endif
        end else begin
            phase_update <= 1'b0;
            case (state)
                ACCUM: begin
                    if (hit_up || hit_dn) begin
                        phase_shift  <= hit_up ? phase_shift + step_mag : phase_shift - step_mag;
                        acc          <= '0;
                        phase_update <= 1'b1;
                        state        <= HOLD;
                        hold_cnt     <= 4'(HOLDOFF - 1);
                        have_dir     <= 1'b1;
                        last_up      <= hit_up;
                        if (!locked && rev_nx == LOCK_N) begin
                            locked   <= 1'b1;
                            rev_cnt  <= '0;
                            same_cnt <= '0;
                        end else if (locked && same_nx == LOCK_N) begin
                            locked   <= 1'b0;
                            rev_cnt  <= '0;
                            same_cnt <= '0;
                        end else begin
                            rev_cnt  <= rev_nx;
                            same_cnt <= same_nx;
                        end
                    end else begin
                        acc <= acc_sum;
                    end
                end
                HOLD: begin
                    acc <= '0;
                    if (hold_cnt == '0)
                        state <= ACCUM;
                    else
                        hold_cnt <= hold_cnt - 4'd1;
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_cdr_phase_controller.sv
// Randomized plus directed bench for cdr_phase_controller against a cycle-level behavioural model.
// Define CDR_PHASE_OVERRIDE_EN for both files to exercise the override ports.
module tb_cdr_phase_controller;

    localparam int T    = 8;
    localparam int HOLD = 4;
    localparam int ACQ  = 4;
    localparam int LREV = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pd_valid, pd_early, pd_late;
    logic [8:0] phase_shift;
    logic       phase_update;
    logic       locked;
`ifdef CDR_PHASE_OVERRIDE_EN
    logic       ovr_en = 1'b0;
    logic [8:0] ovr_code = '0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    int m_acc, m_hold, m_code, m_locked, m_rev, m_same, m_last;
    int m_upd;

    cdr_phase_controller #(
        .VOTE_THRESH(T),
        .HOLDOFF(HOLD),
        .ACQ_STEP(ACQ),
        .LOCK_REV(LREV)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .pd_valid(pd_valid),
        .pd_early(pd_early),
        .pd_late(pd_late),
`ifdef CDR_PHASE_OVERRIDE_EN
        .ovr_en(ovr_en),
        .ovr_code(ovr_code),
`endif
        .phase_shift(phase_shift),
        .phase_update(phase_update),
        .locked(locked)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        int v, d, sz;
        m_upd = 0;
        v = 0;
        if (pd_valid && pd_late && !pd_early) v = 1;
        else if (pd_valid && pd_early && !pd_late) v = -1;
        if (!rst_n) begin
            m_acc = 0; m_hold = 0; m_code = 0; m_locked = 0;
            m_rev = 0; m_same = 0; m_last = 0;
            return;
        end
`ifdef CDR_PHASE_OVERRIDE_EN
        if (ovr_en) begin
            m_upd  = (int'(ovr_code) != m_code) ? 1 : 0;
            m_code = int'(ovr_code);
            m_acc = 0; m_rev = 0; m_same = 0; m_hold = 0;
            return;
        end
`endif
        if (m_hold > 0) begin
            m_hold--;
            return;
        end
        m_acc += v;
        if (m_acc == T || m_acc == -T) begin
            d      = (m_acc > 0) ? 1 : -1;
            sz     = m_locked ? 1 : ACQ;
            m_code = (m_code + d * sz + 512) % 512;
            if (m_last != 0) begin
                if (d != m_last) begin
                    m_rev  = (m_rev < LREV) ? m_rev + 1 : LREV;
                    m_same = 0;
                end else begin
                    m_same = (m_same < LREV) ? m_same + 1 : LREV;
                    m_rev  = 0;
                end
            end
            m_last = d;
            if (!m_locked && m_rev == LREV) begin
                m_locked = 1; m_rev = 0; m_same = 0;
            end else if (m_locked && m_same == LREV) begin
                m_locked = 0; m_rev = 0; m_same = 0;
            end
            m_acc  = 0;
            m_hold = HOLD;
            m_upd  = 1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("phase_shift", 32'(phase_shift), 32'(m_code));
        check("phase_update", 32'(phase_update), 32'(m_upd));
        check("locked", 32'(locked), 32'(m_locked));
    endtask

    // dir: +1 late, -1 early, 0 idle, 2 both early and late
    task automatic set_vote(input int dir);
        pd_valid = (dir != 0);
        pd_late  = (dir == 1 || dir == 2);
        pd_early = (dir == -1 || dir == 2);
    endtask

    task automatic vote_cycles(input int dir, input int n);
        set_vote(dir);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic burst(input int dir);
        vote_cycles(dir, T);
        vote_cycles(0, HOLD);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        vote_cycles(0, 2);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        set_vote(0);
        m_acc = 0; m_hold = 0; m_code = 0; m_locked = 0;
        m_rev = 0; m_same = 0; m_last = 0; m_upd = 0;

        // Reset values, with votes present during reset discarded
        rst_n = 1'b0;
        vote_cycles(1, 3);
        check("rst_phase", 32'(phase_shift), 32'd0);
        check("rst_update", 32'(phase_update), 32'd0);
        check("rst_locked", 32'(locked), 32'd0);
        rst_n = 1'b1;

        // Threshold step and holdoff
        vote_cycles(1, 7);
        check("pre_step", 32'(phase_shift), 32'd0);
        vote_cycles(1, 1);
        check("first_step", 32'(phase_shift), 32'd4);
        check("first_pulse", 32'(phase_update), 32'd1);
        vote_cycles(1, 4);
        check("hold_ignored", 32'(phase_shift), 32'd4);
        vote_cycles(1, 7);
        check("post_hold_acc", 32'(phase_shift), 32'd4);
        vote_cycles(1, 1);
        check("second_step", 32'(phase_shift), 32'd8);

        // Wrap in both directions
        do_reset();
        burst(-1);
        check("wrap_down", 32'(phase_shift), 32'd508);
        burst(1);
        check("wrap_up", 32'(phase_shift), 32'd0);

        // Lock after 8 reversals, track steps of 1, unlock after 8 same-direction steps
        do_reset();
        for (int i = 0; i < 9; i++) begin
            vote_cycles((i % 2 == 0) ? 1 : -1, T);
            if (i == 8) check("lock_on_9th", 32'(locked), 32'd1);
            vote_cycles(0, HOLD);
        end
        check("locked_code", 32'(phase_shift), 32'd4);
        burst(1);
        check("track_step", 32'(phase_shift), 32'd5);
        for (int i = 0; i < 6; i++) burst(1);
        check("still_locked", 32'(locked), 32'd1);
        burst(1);
        check("unlock", 32'(locked), 32'd0);
        check("unlock_code", 32'(phase_shift), 32'd12);
        burst(1);
        check("acq_step_again", 32'(phase_shift), 32'd16);

        // Both votes high: no contribution
        vote_cycles(2, 20);
        check("both_high", 32'(phase_shift), 32'd16);

        // Reset during holdoff
        vote_cycles(1, T);
        check("pre_hold_rst", 32'(phase_shift), 32'd20);
        vote_cycles(0, 2);
        rst_n = 1'b0;
        vote_cycles(0, 1);
        check("hold_rst_phase", 32'(phase_shift), 32'd0);
        check("hold_rst_pulse", 32'(phase_update), 32'd0);
        rst_n = 1'b1;
        vote_cycles(0, 2);

`ifdef CDR_PHASE_OVERRIDE_EN
        ovr_en = 1'b1; ovr_code = 9'h17F;
        vote_cycles(0, 1);
        check("ovr_load", 32'(phase_shift), 32'h17F);
        check("ovr_pulse", 32'(phase_update), 32'd1);
        vote_cycles(1, 3);
        check("ovr_no_repulse", 32'(phase_update), 32'd0);
        ovr_en = 1'b0;
        vote_cycles(1, T);
        check("ovr_resume", 32'(phase_shift), 32'h183);
        vote_cycles(0, HOLD);
        ovr_en = 1'b1; ovr_code = 9'd510;
        vote_cycles(0, 1);
        ovr_en = 1'b0;
        vote_cycles(1, T);
        check("wrap_510", 32'(phase_shift), 32'd2);
        vote_cycles(0, HOLD);
        ovr_en = 1'b1; ovr_code = 9'd1;
        vote_cycles(0, 1);
        ovr_en = 1'b0;
        vote_cycles(-1, T);
        check("wrap_1", 32'(phase_shift), 32'd509);
        vote_cycles(0, HOLD);
`endif

        // Randomized segments against the model
        for (int seg = 0; seg < 80; seg++) begin
            int pat;
            pat = $urandom_range(0, 3);
            for (int c = 0; c < 64; c++) begin
                int r;
                r = $urandom_range(0, 99);
                case (pat)
                    0: begin
                        pd_valid = $urandom_range(0, 1) == 1;
                        pd_early = $urandom_range(0, 1) == 1;
                        pd_late  = $urandom_range(0, 1) == 1;
                    end
                    1: set_vote(r < 80 ? 1 : (r < 90 ? -1 : 0));
                    2: set_vote(r < 80 ? -1 : (r < 90 ? 1 : 0));
                    default: set_vote(((c / (T + HOLD)) % 2 == 0) ? 1 : -1);
                endcase
                rst_n = ($urandom_range(0, 499) != 0);
`ifdef CDR_PHASE_OVERRIDE_EN
                ovr_en   = ($urandom_range(0, 99) < 3);
                ovr_code = 9'($urandom_range(0, 511));
`endif
                tick();
            end
        end
        rst_n = 1'b1;
`ifdef CDR_PHASE_OVERRIDE_EN
        ovr_en = 1'b0;
`endif
        vote_cycles(0, 2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
